// File: rtl/stack_ram_sequencer.sv
// Stack RAM sequencer: runs PUSH/POP/CALL/RET against a 2**ADDR_W-byte RAM,
// driving the external stack pointer and addressing the RAM with its returned value.
module stack_ram_sequencer #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        busy,
  output logic        sp_push,
  output logic        sp_pop,
  output logic        sp_rd,
  input  logic [7:0]  sp_in,
  output logic        ovf,
  output logic        udf,
  input  logic        flag_clr
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [7:0] SP_TOP   = 8'h7F;
  localparam logic [7:0] SP_RESET = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INC,
    S_WR,
    S_RD,
    S_DEC,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]        op_p0;
  logic [15:0]       data_p0;
  logic              byte_idx;
  logic [7:0]        shadow_sp;
  logic              accept;
  logic              ovf_set;
  logic              udf_set;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] wr_byte;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign ram_addr = sp_in[ADDR_W-1:0];
  assign ram_q    = mem[ram_addr];
  assign wr_byte  = byte_idx ? data_p0[15:8] : data_p0[7:0];

  // The stack pointer value is not visible during INC/DEC, so the range
  // checks run on the locally tracked shadow copy instead of sp_in.
  assign ovf_set = (state == S_INC) && (shadow_sp == SP_TOP);
  assign udf_set = (state == S_DEC) && (shadow_sp == 8'h00);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    sp_push    = 1'b0;
    sp_pop     = 1'b0;
    sp_rd      = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        sp_rd     = cmd_valid & reset;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_op == OP_PUSH || cmd_op == OP_CALL) begin
            state_next = S_INC;
          end else begin
            state_next = S_RD;
          end
        end
      end
      S_INC: begin
        sp_push    = 1'b1;
        state_next = S_WR;
      end
      S_WR: begin
        sp_rd = 1'b1;
        if (op_p0 == OP_CALL && !byte_idx) begin
          state_next = S_INC;
        end else begin
          state_next = S_DONE;
        end
      end
      S_RD: begin
        sp_rd      = 1'b1;
        state_next = S_DEC;
      end
      S_DEC: begin
        sp_pop = 1'b1;
        if (op_p0 == OP_RET && !byte_idx) begin
          state_next = S_RD;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Stage p0: command captured at accept, held for the whole sequence
  always_ff @(posedge clock) begin
    if (accept) begin
      op_p0   <= cmd_op;
      data_p0 <= cmd_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      byte_idx  <= 1'b0;
      shadow_sp <= SP_RESET;
      rd_data   <= 16'h0000;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          byte_idx <= 1'b0;
          if (cmd_valid) begin
            shadow_sp <= sp_in;
          end
        end
        S_INC: begin
          shadow_sp <= (shadow_sp == SP_TOP) ? 8'h00 : shadow_sp + 8'd1;
        end
        S_WR: begin
          shadow_sp <= sp_in;
          if (op_p0 == OP_CALL) begin
            byte_idx <= 1'b1;
          end
        end
        S_RD: begin
          shadow_sp <= sp_in;
          if (op_p0 == OP_POP) begin
            rd_data <= {8'h00, ram_q};
          end else if (!byte_idx) begin
            rd_data[15:8] <= ram_q;
          end else begin
            rd_data[7:0] <= ram_q;
          end
        end
        S_DEC: begin
          shadow_sp <= shadow_sp - 8'd1;
          if (op_p0 == OP_RET) begin
            byte_idx <= 1'b1;
          end
        end
        default: begin
        end
      endcase
      // A fresh set outranks a clear arriving on the same edge.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (flag_clr) begin
        ovf <= 1'b0;
      end
      if (udf_set) begin
        udf <= 1'b1;
      end else if (flag_clr) begin
        udf <= 1'b0;
      end
    end
  end

  // RAM contents survive reset; a reset edge just suppresses the write.
  always_ff @(posedge clock) begin
    if (reset && state == S_WR) begin
      mem[ram_addr] <= wr_byte;
    end
  end

endmodule

// File: tb/tb_stack_ram_sequencer.sv
// Scoreboard bench for stack_ram_sequencer with a behavioural stack pointer
// and an abstract stack/RAM reference model.
module tb_stack_ram_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] rd_data;
  logic        done;
  logic        busy;
  logic        sp_push;
  logic        sp_pop;
  logic        sp_rd;
  logic [7:0]  sp_in;
  logic        ovf;
  logic        udf;
  logic        flag_clr;

  logic [7:0]  sp_reg;
  logic        wr_sp;
  logic [7:0]  wr_val;

  always #5 clock = ~clock;

  stack_ram_sequencer #(.ADDR_W(7), .DATA_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rd_data  (rd_data),
    .done     (done),
    .busy     (busy),
    .sp_push  (sp_push),
    .sp_pop   (sp_pop),
    .sp_rd    (sp_rd),
    .sp_in    (sp_in),
    .ovf      (ovf),
    .udf      (udf),
    .flag_clr (flag_clr)
  );

  // Stack pointer block: resets to 07, pre-increments with 7F->00 wrap, decrements freely.
  always @(posedge clock) begin
    if (!reset)            sp_reg <= 8'h07;
    else if (wr_sp)        sp_reg <= wr_val;
    else if (sp_push)      sp_reg <= (sp_reg == 8'h7F) ? 8'h00 : sp_reg + 8'h01;
    else if (sp_pop)       sp_reg <= sp_reg - 8'h01;
  end
  assign sp_in = sp_rd ? sp_reg : 8'h00;

  // Reference model
  logic [7:0]  ram_m    [128];
  logic [7:0]  ram_snap [128];
  logic [7:0]  sp_m;
  logic        ovf_m, udf_m;
  logic [15:0] rd_m;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] rd;
    logic [7:0]  sp;
    logic        ovf;
    logic        udf;
    int          acc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_count = 0;
  int npush = 0;
  int npop = 0;
  bit both_hi = 0;
  bit hold_mode = 0;
  int hold_acc = 0;
  int last_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void m_push(input logic [7:0] d);
    if (sp_m == 8'h7F) begin
      ovf_m = 1'b1;
      sp_m  = 8'h00;
    end else begin
      sp_m = sp_m + 8'h01;
    end
    ram_m[sp_m[6:0]] = d;
  endfunction

  function automatic logic [7:0] m_pop();
    logic [7:0] v;
    v = ram_m[sp_m[6:0]];
    if (sp_m == 8'h00) udf_m = 1'b1;
    sp_m = sp_m - 8'h01;
    return v;
  endfunction

  // Accept side: applies each accepted command to the model and queues the outcome.
  initial begin
    exp_t e;
    logic [7:0] hi, lo;
    forever begin
      @(posedge clock);
      cyc++;
      if (!reset) begin
        q.delete();
        sp_m  = 8'h07;
        ovf_m = 1'b0;
        udf_m = 1'b0;
        rd_m  = 16'h0000;
      end else begin
        if (wr_sp) sp_m = wr_val;
        if (flag_clr && cmd_ready) begin
          ovf_m = 1'b0;
          udf_m = 1'b0;
        end
        if (cmd_valid && busy) check("ready while busy", {31'd0, cmd_ready}, 32'd0);
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            2'b00: m_push(cmd_data[7:0]);
            2'b01: rd_m = {8'h00, m_pop()};
            2'b10: begin
              m_push(cmd_data[7:0]);
              m_push(cmd_data[15:8]);
            end
            default: begin
              hi   = m_pop();
              lo   = m_pop();
              rd_m = {hi, lo};
            end
          endcase
          e.op  = cmd_op;
          e.rd  = rd_m;
          e.sp  = sp_m;
          e.ovf = ovf_m;
          e.udf = udf_m;
          e.acc = cyc;
          q.push_back(e);
          acc_count++;
          npush   = 0;
          npop    = 0;
          both_hi = 0;
          if (hold_mode) begin
            if (hold_acc > 0) check("accept gap", cyc, last_done + 2);
            hold_acc++;
          end
        end
      end
    end
  end

  // Monitor: compares every completed command against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (sp_push) npush++;
        if (sp_pop) npop++;
        if (sp_push && sp_pop) both_hi = 1;
        if (done) begin
          last_done = cyc;
          if (q.size() == 0) begin
            check("unexpected done", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("rd_data", {16'd0, rd_data}, {16'd0, e.rd});
            check("sp", {24'd0, sp_reg}, {24'd0, e.sp});
            check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
            check("udf", {31'd0, udf}, {31'd0, e.udf});
            check("latency", cyc - e.acc, (e.op[1]) ? 32'd4 : 32'd2);
            check("push pulses", npush, (e.op == 2'b00) ? 32'd1 : (e.op == 2'b10) ? 32'd2 : 32'd0);
            check("pop pulses", npop, (e.op == 2'b01) ? 32'd1 : (e.op == 2'b11) ? 32'd2 : 32'd0);
            check("push/pop overlap", {31'd0, both_hi}, 32'd0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] d);
    int start;
    int n;
    start     = acc_count;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    n = 0;
    while (acc_count == start && n < 60) begin
      tick();
      n++;
    end
    if (acc_count == start) check("accept timeout", 32'd0, 32'd1);
    if (!hold_mode) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(q.size() == 0 && !busy) && n < 100) begin
      tick();
      n++;
    end
    if (!(q.size() == 0 && !busy)) check("idle timeout", 32'd0, 32'd1);
  endtask

  task automatic set_sp(input logic [7:0] v);
    wait_idle();
    wr_val = v;
    wr_sp  = 1'b1;
    tick();
    wr_sp  = 1'b0;
  endtask

  task automatic clr_flags();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 16'h0000;
    flag_clr  = 1'b0;
    wr_sp     = 1'b0;
    wr_val    = 8'h00;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset sp strobes", {29'd0, sp_push, sp_pop, sp_rd}, 32'd0);
    check("reset rd_data", {16'd0, rd_data}, 32'd0);
    check("reset flags", {30'd0, ovf, udf}, 32'd0);

    // Basic PUSH/POP and CALL/RET round trips
    issue(2'b00, 16'h00A5); wait_idle();
    issue(2'b01, 16'h0000); wait_idle();
    issue(2'b10, 16'h1234); wait_idle();
    issue(2'b11, 16'h0000); wait_idle();

    // Overflow wrap and clear
    set_sp(8'h7F);
    issue(2'b00, 16'h0055); wait_idle();
    clr_flags();
    check("ovf after clear", {31'd0, ovf}, 32'd0);

    // Underflow reads ram[0] and leaves SP at FF
    set_sp(8'h00);
    issue(2'b01, 16'h0000); wait_idle();

    // Clear arriving on the same edge as a new overflow loses
    clr_flags();
    set_sp(8'h7F);
    issue(2'b00, 16'h0077);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    wait_idle();

    // Reset during the second INC of a CALL
    set_sp(8'h07);
    ram_snap = ram_m;
    issue(2'b10, 16'hBEEF);
    tick();
    tick();
    check("second INC push", {31'd0, sp_push}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort sp_push", {31'd0, sp_push}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort rd_data", {16'd0, rd_data}, 32'd0);
    check("abort flags", {30'd0, ovf, udf}, 32'd0);
    ram_m    = ram_snap;
    ram_m[8] = 8'hEF;
    set_sp(8'h08);
    issue(2'b01, 16'h0000); wait_idle();
    set_sp(8'h09);
    issue(2'b01, 16'h0000); wait_idle();

    // Fill every RAM location so later random reads are defined
    set_sp(8'hFF);
    for (int i = 0; i < 128; i++) begin
      issue(2'b00, 16'($urandom));
      wait_idle();
    end

    // cmd_valid held high across back-to-back commands
    wait_idle();
    hold_mode = 1;
    hold_acc  = 0;
    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(0, 3)), 16'($urandom));
    end
    cmd_valid = 1'b0;
    hold_mode = 0;
    check("hold accepts", hold_acc, 32'd8);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) set_sp(8'($urandom_range(0, 255)));
      if (r == 1) begin
        wait_idle();
        clr_flags();
      end
      issue(2'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    check("leftover expectations", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ram_sequencer.md
Name: stack_ram_sequencer

Overview:
- Downstream consumer of the 8-bit stack pointer block (Stack_Pointer). Owns the 128-byte internal stack RAM.
- Executes PUSH, POP, CALL and RET as multi-cycle sequences.
  - Drives push/pop/rd_sp pulses to the stack pointer.
  - Uses the returned SP value as the RAM address.
- Sits between the CPU control unit (command side) and the stack pointer.

Parameters:
- ADDR_W, 7, RAM address width; RAM depth = 2**ADDR_W bytes.
- DATA_W, 8, RAM word width; SP width is also 8.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; command accepted on clock edge when cmd_valid & cmd_ready.
- cmd_op  input  2  00=PUSH, 01=POP, 10=CALL, 11=RET.
- cmd_data  input  16  PUSH uses [7:0]; CALL uses full return address; ignored for POP/RET. Captured at accept.
- rd_data  output  16  POP result in [7:0] with [15:8]=0; RET result = full 16-bit address. Held until next POP/RET completes.
- done  output  1  one-cycle pulse in the DONE state.
- busy  output  1  high in every state except IDLE.
- sp_push  output  1  to stack pointer push input.
- sp_pop  output  1  to stack pointer pop input.
- sp_rd  output  1  to stack pointer rd_sp input.
- sp_in  input  8  stack pointer data_out_SP; valid only while sp_rd=1.
- ovf  output  1  sticky overflow flag.
- udf  output  1  sticky underflow flag.
- flag_clr  input  1  clears ovf/udf on the next edge; a new set on the same edge wins.

Behaviour:
- States: IDLE, INC, WR, RD, DEC, DONE. A 1-bit byte-index register tracks lo/hi for CALL/RET.
- Output decode:
  - sp_push=1 only in INC; sp_pop=1 only in DEC; sp_rd=1 only in WR and RD.
  - At most one of sp_push/sp_pop is ever high.
- RAM address = sp_in[ADDR_W-1:0]. No RAM write or read happens outside WR/RD.
- PUSH, accepted at edge N:
  - INC during N..N+1.
  - WR during N+1..N+2; ram[sp] <= cmd_data[7:0] at edge N+2.
  - DONE during N+2..N+3, then IDLE.
- POP, accepted at edge N:
  - RD: rd_data <= {8'h00, ram[sp]} at edge N+1.
  - DEC during N+1..N+2.
  - DONE during N+2..N+3.
- CALL: INC, WR(lo=cmd_data[7:0]), INC, WR(hi=cmd_data[15:8]), DONE. done in the 5th cycle after accept. Net SP +2.
- RET: RD(hi into rd_data[15:8]), DEC, RD(lo into rd_data[7:0]), DEC, DONE. done in the 5th cycle. Net SP -2.
  - rd_data bytes update as read; rd_data is final when done=1.
- Pre-increment on push, post-decrement on pop, matching the stack pointer block's update rules.
- Overflow: ovf sets when in INC with sp_in==8'h7F. Sequence continues; the stack pointer wraps to 8'h00 and the write lands at ram[0].
  - INC does not assert sp_rd, so the sequencer samples sp_in via a shadow SP register. The shadow is loaded in every WR/RD state and updated +1 (wrap 7F->00) / -1 in INC/DEC; ovf/udf test the shadow.
  - The shadow is loaded at accept via a one-cycle sp_rd in IDLE when cmd_valid=1. cmd_ready still requires IDLE.
- Underflow: udf sets when in DEC with shadow==8'h00. The stack pointer goes to 8'hFF; the sequence continues.
- cmd_valid while busy: ignored; cmd_ready=0, so no accept.
- Reset (reset=0 at an edge), at any state including mid-CALL/RET:
  - Next state IDLE.
  - busy=0, done=0, sp_push=sp_pop=sp_rd=0.
  - rd_data=16'h0000, ovf=udf=0, shadow=8'h07.
  - RAM contents are not cleared; partially executed writes remain.
- Reset values: cmd_ready=1 once reset deasserts; all other outputs 0.
- No combinational path from cmd_valid to sp_push/sp_pop. sp_rd in IDLE does depend on cmd_valid.

Test Plan:
- Bench instantiates Stack_Pointer (SP=07 after reset) wired to sp_* ports.
- PUSH 0x00A5 after reset -> sp_push pulse 1 cycle, ram[08]=A5, SP=08, done 2 cycles after INC, busy high 3 cycles.
- Then POP -> rd_data=16'h00A5 when done=1, one sp_pop pulse, SP=07, ovf=udf=0.
- CALL 0x1234 then RET:
  - After CALL: ram[08]=34, ram[09]=12, SP=09, done on 5th cycle.
  - RET: rd_data=16'h1234, SP=07.
- Write SP=7F via wr_sp, then PUSH 0x0055 -> ovf=1, SP=00, ram[00]=55; flag_clr pulse -> ovf=0.
- Write SP=00, then POP -> udf=1, SP=FF, rd_data=16'h00 followed by ram[00].
- Reset mid-sequence and back-pressure:
  - Assert reset low during second INC of CALL 0xBEEF from SP=07 -> next cycle IDLE, busy=0, no sp_push, ram[08]=EF retained.
  - Hold cmd_valid high throughout -> exactly one accept per IDLE cycle, none while busy.
